// File: rtl/uart_avm_sequencer.sv
// Avalon-MM master that drives a uart_core register port: round-robin TX arbitration with
// STATUS polling, and IRQ-driven RX reads forwarded on a one-cycle strobe.
module uart_avm_sequencer #(
   parameter int          NUM_REQ     = 2,
   parameter int          POLL_GAP    = 16,
   parameter logic [3:0]  TXDATA_ADDR = 4'h0,
   parameter logic [3:0]  STATUS_ADDR = 4'h1,
   parameter logic [3:0]  RXDATA_ADDR = 4'h2
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*8-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [7:0]           rx_data_o,
   output logic                 rx_valid_o,
   output logic [3:0]           avm_address_o,
   output logic                 avm_read_o,
   output logic                 avm_write_o,
   output logic [7:0]           avm_writedata_o,
   input  logic [7:0]           avm_readdata_i,
   input  logic                 irq_i,
   output logic                 busy_o
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(POLL_GAP + 1);

   typedef enum logic [2:0] {IDLE, ST_RD, ST_CHK, WR, GAP, RX_RD, RX_CAP} state_t;

   state_t               state_reg;
   logic                 locked_reg;
   logic [GW-1:0]        grant_reg;
   logic [GW-1:0]        last_grant_reg;
   logic [CW-1:0]        gap_cnt_reg;
   logic [3:0]           addr_reg;
   logic                 read_reg;
   logic                 write_reg;
   logic [NUM_REQ-1:0]   ready_reg;
   logic                 rx_valid_reg;
   logic [7:0]           rx_data_reg;

   logic [7:0]           req_byte [NUM_REQ];
   logic                 rr_found;
   logic [GW-1:0]        rr_winner;
   int                   rr_idx;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
         assign req_byte[gi] = req_data_i[8*gi +: 8];
      end
   endgenerate

   // Search starts just after the last served requester so every requester gets a turn.
   always_comb begin
      rr_found  = 1'b0;
      rr_winner = '0;
      rr_idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_idx = (int'(last_grant_reg) + 1 + i) % NUM_REQ;
         if (!rr_found && req_valid_i[rr_idx]) begin
            rr_found  = 1'b1;
            rr_winner = rr_idx[GW-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_reg      <= IDLE;
         locked_reg     <= 1'b0;
         grant_reg      <= '0;
         last_grant_reg <= GW'(NUM_REQ - 1);
         gap_cnt_reg    <= '0;
         addr_reg       <= 4'h0;
         read_reg       <= 1'b0;
         write_reg      <= 1'b0;
         ready_reg      <= '0;
         rx_valid_reg   <= 1'b0;
         rx_data_reg    <= 8'h00;
      end else begin
         read_reg     <= 1'b0;
         write_reg    <= 1'b0;
         ready_reg    <= '0;
         rx_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (irq_i) begin
                  state_reg <= RX_RD;
                  read_reg  <= 1'b1;
                  addr_reg  <= RXDATA_ADDR;
               end else if (locked_reg) begin
                  state_reg <= ST_RD;
                  read_reg  <= 1'b1;
                  addr_reg  <= STATUS_ADDR;
               end else if (rr_found) begin
                  locked_reg <= 1'b1;
                  grant_reg  <= rr_winner;
                  state_reg  <= ST_RD;
                  read_reg   <= 1'b1;
                  addr_reg   <= STATUS_ADDR;
               end
            end
            ST_RD: state_reg <= ST_CHK;
            ST_CHK: begin
               if (avm_readdata_i[0]) begin
                  state_reg <= WR;
                  write_reg <= 1'b1;
                  addr_reg  <= TXDATA_ADDR;
                  ready_reg <= NUM_REQ'(1) << grant_reg;
               end else begin
                  state_reg   <= GAP;
                  gap_cnt_reg <= CW'(POLL_GAP - 1);
               end
            end
            WR: begin
               last_grant_reg <= grant_reg;
               locked_reg     <= 1'b0;
               state_reg      <= IDLE;
            end
            // Returning to IDLE between polls keeps the grant but lets a pending IRQ in first.
            GAP: begin
               if (gap_cnt_reg == '0) state_reg <= IDLE;
               else                   gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
            RX_RD: begin
               state_reg    <= RX_CAP;
               rx_valid_reg <= 1'b1;
            end
            RX_CAP: begin
               rx_data_reg <= avm_readdata_i;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Read data only arrives during RX_CAP, so the strobe cycle passes it straight through.
   assign rx_data_o       = (state_reg == RX_CAP) ? avm_readdata_i : rx_data_reg;
   assign rx_valid_o      = rx_valid_reg;
   assign avm_writedata_o = (state_reg == WR) ? req_byte[grant_reg] : 8'h00;
   assign avm_address_o   = addr_reg;
   assign avm_read_o      = read_reg;
   assign avm_write_o     = write_reg;
   assign req_ready_o     = ready_reg;
   assign busy_o          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_avm_sequencer.sv
// Scoreboard bench for uart_avm_sequencer: scripted stimulus queues expected bus events
// with their cycle numbers; a negedge monitor pops and compares each event the DUT presents.
module tb_uart_avm_sequencer;

   localparam int N = 2;
   localparam logic [3:0] A_TX = 4'h0;
   localparam logic [3:0] A_ST = 4'h1;
   localparam logic [3:0] A_RX = 4'h2;

   logic           clk_i = 1'b0;
   logic           arst_n_i = 1'b0;
   logic [N-1:0]   req_valid_i = '0;
   logic [8*N-1:0] req_data_i = '0;
   logic [N-1:0]   req_ready_o;
   logic [7:0]     rx_data_o;
   logic           rx_valid_o;
   logic [3:0]     avm_address_o;
   logic           avm_read_o;
   logic           avm_write_o;
   logic [7:0]     avm_writedata_o;
   logic [7:0]     avm_readdata_i = 8'h00;
   logic           irq_i = 1'b0;
   logic           busy_o;

   uart_avm_sequencer #(.NUM_REQ(N), .POLL_GAP(16)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
      .avm_writedata_o(avm_writedata_o), .avm_readdata_i(avm_readdata_i),
      .irq_i(irq_i), .busy_o(busy_o)
   );

   typedef struct {
      int         kind;   // 0 read, 1 write, 2 rx strobe
      logic [3:0] addr;
      logic [7:0] data;
      logic [N-1:0] rdy;
      int         cyc;
   } ev_t;

   ev_t        sb_q[$];
   logic [7:0] status_q[$];
   logic [7:0] rx_byte = 8'h00;
   int         cyc = 0;
   int         compared = 0;
   int         errors = 0;

   initial forever #5 clk_i = ~clk_i;
   initial forever begin @(posedge clk_i); cyc = cyc + 1; end

   // uart_core slave model: read data appears in the cycle after the strobe and holds.
   initial forever begin
      @(negedge clk_i);
      if (avm_read_o) begin
         if (avm_address_o == A_ST) begin
            if (status_q.size() > 0) avm_readdata_i = status_q.pop_front();
            else                     avm_readdata_i = 8'h01;
         end else if (avm_address_o == A_RX) begin
            avm_readdata_i = rx_byte;
            irq_i = 1'b0;
         end else begin
            avm_readdata_i = 8'hEE;
         end
      end
   end

   task automatic exp_ev(input int kind, input logic [3:0] addr, input logic [7:0] data,
                         input logic [N-1:0] rdy, input int at);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.rdy = rdy; e.cyc = at;
      sb_q.push_back(e);
   endtask

   task automatic check_ev(input int kind, input logic [3:0] addr, input logic [7:0] data,
                           input logic [N-1:0] rdy);
      ev_t e;
      compared++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h rdy=%b at cycle %0d, none expected",
                  kind, addr, data, rdy, cyc);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.addr != addr || e.data != data || e.rdy != rdy || e.cyc != cyc) begin
            errors++;
            $display("FAIL bus_event: got kind=%0d addr=%h data=%h rdy=%b cyc=%0d, expected kind=%0d addr=%h data=%h rdy=%b cyc=%0d",
                     kind, addr, data, rdy, cyc, e.kind, e.addr, e.data, e.rdy, e.cyc);
         end
      end
   endtask

   initial forever begin
      @(negedge clk_i);
      if (req_ready_o != '0 && !avm_write_o) begin
         compared++;
         errors++;
         $display("FAIL stray_ready: req_ready_o=%b without a write at cycle %0d", req_ready_o, cyc);
      end
      if (avm_read_o)  check_ev(0, avm_address_o, 8'h00, req_ready_o);
      if (avm_write_o) check_ev(1, avm_address_o, avm_writedata_o, req_ready_o);
      if (rx_valid_o)  check_ev(2, 4'h0, rx_data_o, req_ready_o);
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      compared++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic step_to(input int t);
      while (cyc < t) begin @(posedge clk_i); #1; end
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (sb_q.size() != 0 && k < budget) begin @(posedge clk_i); #1; k++; end
      if (sb_q.size() != 0) begin
         compared++;
         errors++;
         $display("FAIL drain_timeout: %0d expected events never appeared", sb_q.size());
         sb_q.delete();
      end
      @(posedge clk_i); #1;
   endtask

   int c;

   initial begin
      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_busy",      {7'd0, busy_o},      8'h00);
      check("rst_ready",     {6'd0, req_ready_o}, 8'h00);
      check("rst_rx_valid",  {7'd0, rx_valid_o},  8'h00);
      check("rst_rx_data",   rx_data_o,           8'h00);
      check("rst_address",   {4'd0, avm_address_o}, 8'h00);
      check("rst_read",      {7'd0, avm_read_o},  8'h00);
      check("rst_write",     {7'd0, avm_write_o}, 8'h00);
      check("rst_writedata", avm_writedata_o,     8'h00);
      @(posedge clk_i); #1;
      arst_n_i = 1'b1;

      // Single requester, transmitter ready
      c = cyc + 2; step_to(c);
      req_data_i[7:0] = 8'h48; req_valid_i = 2'b01;
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 1);
      exp_ev(1, A_TX, 8'h48, 2'b01, c + 3);
      step_to(c + 4); req_valid_i = '0;
      drain(10);

      // Not ready twice: retry period 3 + POLL_GAP
      c = cyc + 1; step_to(c);
      status_q.push_back(8'h00); status_q.push_back(8'h00); status_q.push_back(8'h01);
      req_data_i[7:0] = 8'h33; req_valid_i = 2'b01;
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 1);
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 20);
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 39);
      exp_ev(1, A_TX, 8'h33, 2'b01, c + 41);
      step_to(c + 42); req_valid_i = '0;
      drain(10);

      // Reset so requester 0 wins first, then both requesters continuously valid
      arst_n_i = 1'b0;
      step_to(cyc + 2);
      arst_n_i = 1'b1;
      c = cyc + 2; step_to(c);
      req_data_i = {8'hB0, 8'hA0}; req_valid_i = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_ev(0, A_ST, 8'h00, 2'b00, c + 1 + 4*k);
         exp_ev(1, A_TX, (k % 2 == 0) ? 8'hA0 : 8'hB0, (k % 2 == 0) ? 2'b01 : 2'b10, c + 3 + 4*k);
      end
      step_to(c + 16); req_valid_i = '0;
      drain(10);

      // IRQ and requester 1 together: RX read goes first
      c = cyc + 1; step_to(c);
      irq_i = 1'b1; rx_byte = 8'h6E;
      req_data_i[15:8] = 8'h11; req_valid_i = 2'b10;
      exp_ev(0, A_RX, 8'h00, 2'b00, c + 1);
      exp_ev(2, 4'h0, 8'h6E, 2'b00, c + 2);
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 4);
      exp_ev(1, A_TX, 8'h11, 2'b10, c + 6);
      step_to(c + 7); req_valid_i = '0;
      drain(10);

      // Lock on requester 1, IRQ during GAP, requester 0 appears: retry still serves 1
      c = cyc + 1; step_to(c);
      status_q.push_back(8'h00);
      req_data_i[15:8] = 8'hC5; req_valid_i = 2'b10;
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 1);
      step_to(c + 5);
      irq_i = 1'b1; rx_byte = 8'h9D;
      req_data_i[7:0] = 8'h22; req_valid_i = 2'b11;
      exp_ev(0, A_RX, 8'h00, 2'b00, c + 20);
      exp_ev(2, 4'h0, 8'h9D, 2'b00, c + 21);
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 23);
      exp_ev(1, A_TX, 8'hC5, 2'b10, c + 25);
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 27);
      exp_ev(1, A_TX, 8'h22, 2'b01, c + 29);
      step_to(c + 26); req_valid_i = 2'b01;
      step_to(c + 30); req_valid_i = '0;
      drain(10);

      // Reset asserted in ST_CHK: outputs clear at once, byte written once after release
      c = cyc + 1; step_to(c);
      req_data_i[7:0] = 8'h7E; req_valid_i = 2'b01;
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 1);
      step_to(c + 2);
      arst_n_i = 1'b0;
      #1;
      check("midrst_busy",    {7'd0, busy_o},        8'h00);
      check("midrst_address", {4'd0, avm_address_o}, 8'h00);
      check("midrst_ready",   {6'd0, req_ready_o},   8'h00);
      check("midrst_rx_data", rx_data_o,             8'h00);
      step_to(c + 4);
      arst_n_i = 1'b1;
      exp_ev(0, A_ST, 8'h00, 2'b00, c + 5);
      exp_ev(1, A_TX, 8'h7E, 2'b01, c + 7);
      step_to(c + 8); req_valid_i = '0;
      drain(10);
      repeat (5) begin @(posedge clk_i); #1; end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
      $finish;
   end

endmodule

// File: doc/uart_avm_sequencer.md
# uart_avm_sequencer

Avalon-MM master that sequences a `uart_core` slave on behalf of several byte producers and one byte consumer. It arbitrates round-robin among `NUM_REQ` transmit requesters and polls STATUS bit 0 until the transmitter is ready. It then writes the granted byte to TXDATA. On `IRQ_event` it reads the received byte and forwards it on a one-cycle valid strobe. It sits between the system's byte streams and the `uart_core` register port, so software needs no polling loop.

## Interface
- `NUM_REQ`, default 2: number of transmit requesters (2..8).
- `POLL_GAP`, default 16: idle cycles inserted after a STATUS read reports "not ready" (≥1).
- `TXDATA_ADDR`, default 4'h0: `uart_core` transmit data register.
- `STATUS_ADDR`, default 4'h1: `uart_core` status register; bit 0 = TX ready.
- `RXDATA_ADDR`, default 4'h2: `uart_core` receive data / IRQ register.

Ports:
- `clk_i`  in  1  single clock.
- `arst_n_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester byte valid.
- `req_data_i`  in  NUM_REQ*8  flattened bytes; requester k uses bits [8k+7:8k].
- `req_ready_o`  out  NUM_REQ  one-hot acceptance strobe.
- `rx_data_o`  out  8  last received byte.
- `rx_valid_o`  out  1  one-cycle strobe; `rx_data_o` is valid in that cycle.
- `avm_address_o`  out  4  register address.
- `avm_read_o`  out  1  read strobe.
- `avm_write_o`  out  1  write strobe.
- `avm_writedata_o`  out  8  write data.
- `avm_readdata_i`  in  8  slave read data.
- `irq_i`  in  1  `IRQ_event` from `uart_core` (level).
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ST_RD, ST_CHK, WR, GAP, RX_RD, RX_CAP.
- IDLE, first check: `irq_i`=1 → RX_RD. Receive has priority over transmit.
- IDLE, otherwise:
  - If a grant is locked, go to ST_RD.
  - Else, if any `req_valid_i` is set, select a winner round-robin. The search starts at `last_grant+1` modulo NUM_REQ. Lock the grant and go to ST_RD.
- ST_RD: `avm_read_o`=1, `avm_address_o`=STATUS_ADDR for one cycle → ST_CHK.
- ST_CHK: sample `avm_readdata_i[0]`.
  - 1 → WR.
  - 0 → GAP; load the gap counter with POLL_GAP−1.
- GAP: decrement the counter; at 0 → IDLE. The grant stays locked. This lets `irq_i` be serviced between polls.
- WR:
  - `avm_write_o`=1, `avm_address_o`=TXDATA_ADDR, `avm_writedata_o` = byte of the granted requester.
  - `req_ready_o[grant]`=1 in the same cycle.
  - `last_grant` ← grant; unlock → IDLE.
- RX_RD: `avm_read_o`=1, `avm_address_o`=RXDATA_ADDR for one cycle → RX_CAP.
- RX_CAP: `rx_data_o` ← `avm_readdata_i`, `rx_valid_o`=1 → IDLE.
- Requester contract:
  - Hold `req_valid_i` and data stable until the requester's ready bit pulses.
  - Dropping valid while locked is illegal; the sequencer still writes the byte present at WR.
- Slave contract:
  - Read data is valid in the cycle after the read strobe.
  - `irq_i` deasserts no later than the RX_CAP cycle.
- There is no RX backpressure. The consumer must take `rx_data_o` in the `rx_valid_o` cycle.
- Outside ST_RD, WR and RX_RD: `avm_read_o`=`avm_write_o`=0, `avm_writedata_o`=0, `avm_address_o` holds its last value.

## Timing
- Reset (async assert, sync release):
  - State IDLE, grant unlocked, `last_grant`=NUM_REQ−1 (so requester 0 wins first), gap counter 0.
  - All outputs 0, including `avm_address_o` and `rx_data_o`.
- Reset mid-transaction: the pending byte is not consumed (no ready strobe). The requester re-presents it.
- TX latency with the transmitter ready: IDLE sees valid in cycle N; read in N+1; check in N+2; write and `req_ready_o` in N+3.
- Not-ready retry period: 3 + POLL_GAP cycles from one STATUS read to the next, if no IRQ intervenes.
- RX latency: `irq_i` seen in IDLE at cycle N; read in N+1; `rx_valid_o` in N+2.
- Simultaneous `irq_i` and a requester valid in IDLE: the RX read goes first. TX arbitration follows on the next IDLE.
- IRQ arriving during ST_RD, ST_CHK or WR: not serviced until the next IDLE. It is never lost because it is a level.
- Round-robin wrap: after grant NUM_REQ−1, the search restarts at 0.
- At most one of `req_ready_o` bits is high in any cycle, and only in WR.

## Test plan
- Single requester, STATUS returns 0x01: `req_data`=0x48 → STATUS read then TXDATA write 0x48 at valid+3; `req_ready_o`=01 in that cycle.
- STATUS returns 0x00 twice then 0x01 (POLL_GAP=16) → three STATUS reads spaced 19 cycles apart; exactly one write; no ready strobe before it.
- Both requesters valid continuously with bytes 0xA0 and 0xB0 → writes alternate 0xA0, 0xB0, 0xA0, 0xB0; req0 wins first after reset.
- `irq_i` raised with slave RXDATA=0x6E while a requester is valid → read of address 2 precedes the STATUS read; `rx_data_o`=0x6E with a one-cycle `rx_valid_o`.
- IRQ raised during GAP with a locked grant on req1 → RX serviced, then the retry still serves req1 even though req0 is now valid.
- `arst_n_i` pulsed low in ST_CHK → all outputs 0 immediately; no ready strobe; after release, the same byte is written exactly once.
